// File: rtl/matrix_bp_engine.sv
// Backward-pass engine: streams delta and weight rows in, accumulates the
// transposed product e[j] = sum_i w[i][j]*delta[i] in Q6.10, streams e out.
module matrix_bp_engine #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_delta_tdata,
    input  logic        s_delta_tvalid,
    output logic        s_delta_tready,
    input  logic [15:0] s_w_tdata,
    input  logic        s_w_tvalid,
    output logic        s_w_tready,
    output logic [15:0] m_e_tdata,
    output logic        m_e_tvalid,
    input  logic        m_e_tready,
    output logic        m_e_tlast,
    output logic        busy
);

    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELTA  = 2'd1,
        S_WEIGHT = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [N_IN-1:0][15:0]  acc_r, acc_s;
    logic [15:0]            d_r, d_s;
    logic [IW-1:0]          i_r, i_s;
    logic [JW-1:0]          j_r, j_s;
    logic [JW-1:0]          k_r, k_s;
    logic                   busy_s;
    logic [15:0]            inc_s;

    // Q6.10 product slice: arithmetic shift right by 10, truncating toward -inf
    function automatic logic [15:0] q_mul_inc(input logic [15:0] d, input logic [15:0] w);
        logic signed [31:0] p;
        p = $signed(d) * $signed(w);
        return p[25:10];
    endfunction

    // Next-state, counter and accumulator update logic
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        d_s     = d_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        busy_s  = busy;
        inc_s   = q_mul_inc(d_r, s_w_tdata);
        case (state_r)
            S_IDLE: begin
                acc_s   = '0;
                i_s     = '0;
                j_s     = '0;
                k_s     = '0;
                state_s = S_DELTA;
            end
            S_DELTA: begin
                if (s_delta_tvalid) begin
                    d_s     = s_delta_tdata;
                    busy_s  = 1'b1;
                    state_s = S_WEIGHT;
                end else begin
                    state_s = S_DELTA;
                end
            end
            S_WEIGHT: begin
                if (s_w_tvalid) begin
                    acc_s[j_r] = acc_r[j_r] + inc_s;
                    if (j_r == J_LAST) begin
                        j_s = '0;
                        if (i_r == I_LAST) begin
                            state_s = S_OUT;
                        end else begin
                            i_s     = i_r + 1'b1;
                            state_s = S_DELTA;
                        end
                    end else begin
                        j_s = j_r + 1'b1;
                    end
                end else begin
                    state_s = S_WEIGHT;
                end
            end
            S_OUT: begin
                if (m_e_tready) begin
                    if (k_r == J_LAST) begin
                        busy_s  = 1'b0;
                        state_s = S_IDLE;
                    end else begin
                        k_s = k_r + 1'b1;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Core state, datapath and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            acc_r   <= '0;
            d_r     <= 16'h0000;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            d_r     <= d_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
        end
    end

    // Output registers, decoded from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_delta_tready <= 1'b0;
            s_w_tready     <= 1'b0;
            m_e_tvalid     <= 1'b0;
            m_e_tlast      <= 1'b0;
            m_e_tdata      <= 16'h0000;
            busy           <= 1'b0;
        end else begin
            s_delta_tready <= (state_s == S_DELTA);
            s_w_tready     <= (state_s == S_WEIGHT);
            m_e_tvalid     <= (state_s == S_OUT);
            m_e_tlast      <= (state_s == S_OUT) && (k_s == J_LAST);
            m_e_tdata      <= (state_s == S_OUT) ? acc_s[k_s] : 16'h0000;
            busy           <= busy_s;
        end
    end

endmodule

// File: tb/tb_matrix_bp_engine.sv
// Self-checking bench for matrix_bp_engine: directed jobs checked against a
// plain-arithmetic model of the transposed Q6.10 product.
module tb_matrix_bp_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_delta_tdata;
    logic        s_delta_tvalid;
    logic        s_delta_tready;
    logic [15:0] s_w_tdata;
    logic        s_w_tvalid;
    logic        s_w_tready;
    logic [15:0] m_e_tdata;
    logic        m_e_tvalid;
    logic        m_e_tready;
    logic        m_e_tlast;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit bp_mode = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] job_d [N_OUT];
    logic [15:0] job_w [N_OUT*N_IN];

    matrix_bp_engine #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_delta_tdata(s_delta_tdata), .s_delta_tvalid(s_delta_tvalid), .s_delta_tready(s_delta_tready),
        .s_w_tdata(s_w_tdata), .s_w_tvalid(s_w_tvalid), .s_w_tready(s_w_tready),
        .m_e_tdata(m_e_tdata), .m_e_tvalid(m_e_tvalid), .m_e_tready(m_e_tready),
        .m_e_tlast(m_e_tlast), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // e[j] = sum_i floor(delta[i]*w[i][j] / 1024), wrapped to 16 bits
    function automatic logic [15:0] model_e(input int j);
        longint s;
        longint p;
        s = 0;
        for (int i = 0; i < N_OUT; i++) begin
            p = longint'($signed(job_d[i])) * longint'($signed(job_w[i*N_IN+j]));
            s = s + (p >>> 10);
        end
        return s[15:0];
    endfunction

    task automatic set_job(input logic [N_OUT*16-1:0] d, input logic [N_OUT*N_IN*16-1:0] w);
        for (int i = 0; i < N_OUT; i++) job_d[i] = d[(N_OUT-1-i)*16 +: 16];
        for (int n = 0; n < N_OUT*N_IN; n++) job_w[n] = w[(N_OUT*N_IN-1-n)*16 +: 16];
    endtask

    task automatic send(input bit is_w, input logic [15:0] data, input bit gaps);
        int t;
        bit hs;
        t  = 0;
        hs = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        if (is_w) begin s_w_tdata = data; s_w_tvalid = 1'b1; end
        else begin s_delta_tdata = data; s_delta_tvalid = 1'b1; end
        while (!hs && t < 100) begin
            hs = is_w ? s_w_tready : s_delta_tready;
            @(posedge clk); #1;
            t++;
        end
        s_w_tvalid     = 1'b0;
        s_delta_tvalid = 1'b0;
        check(is_w ? "w_handshake" : "delta_handshake", 32'(hs), 32'd1);
    endtask

    task automatic run_job(input bit gaps);
        int t;
        for (int j = 0; j < N_IN; j++) exp_q.push_back(model_e(j));
        for (int i = 0; i < N_OUT; i++) begin
            send(1'b0, job_d[i], gaps);
            if (i == 0) check("busy_set", 32'(busy), 32'd1);
            for (int j = 0; j < N_IN; j++) send(1'b1, job_w[i*N_IN+j], gaps);
        end
        check("first_result_latency", 32'(m_e_tvalid), 32'd1);
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("job_drain", 32'(t < 200), 32'd1);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dready"}, 32'(s_delta_tready), 32'd0);
        check({tag, "_wready"}, 32'(s_w_tready), 32'd0);
        check({tag, "_evalid"}, 32'(m_e_tvalid), 32'd0);
        check({tag, "_edata"}, 32'(m_e_tdata), 32'd0);
        check({tag, "_elast"}, 32'(m_e_tlast), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_first_cycle_dready", 32'(s_delta_tready), 32'd0);
        @(posedge clk); #1;
        check("second_cycle_dready", 32'(s_delta_tready), 32'd1);
    endtask

    // Downstream ready: always-on, or random 0/1 under backpressure
    initial begin
        m_e_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_e_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output compare: beat data/tlast vs model, hold under stall, post-job gap
    initial begin
        bit          stall_prev;
        logic [15:0] prev_data;
        logic        prev_last;
        int          beat_idx;
        int          post_last;
        logic [15:0] exp;
        stall_prev = 1'b0;
        prev_data  = 16'h0000;
        prev_last  = 1'b0;
        beat_idx   = 0;
        post_last  = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
                beat_idx   = 0;
                post_last  = 0;
            end else begin
                if (post_last == 1) begin
                    check("gap_dready_low", 32'(s_delta_tready), 32'd0);
                    check("gap_busy_low", 32'(busy), 32'd0);
                    check("gap_evalid_low", 32'(m_e_tvalid), 32'd0);
                    post_last = 2;
                end else if (post_last == 2) begin
                    check("dready_two_after_last", 32'(s_delta_tready), 32'd1);
                    post_last = 0;
                end
                if (m_e_tvalid && stall_prev) begin
                    check("hold_data", 32'(m_e_tdata), 32'(prev_data));
                    check("hold_last", 32'(m_e_tlast), 32'(prev_last));
                end
                if (m_e_tvalid && m_e_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("e_data", 32'(m_e_tdata), 32'(exp));
                        check("e_last", 32'(m_e_tlast), 32'(beat_idx == N_IN-1));
                    end
                    if (beat_idx == N_IN-1) begin
                        beat_idx  = 0;
                        post_last = 1;
                    end else begin
                        beat_idx++;
                    end
                end
                stall_prev = m_e_tvalid && !m_e_tready;
                prev_data  = m_e_tdata;
                prev_last  = m_e_tlast;
            end
        end
    end

    localparam logic [N_OUT*N_IN*16-1:0] W_BASIC = {
        16'h0400, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0400, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0400, 16'h0200};
    localparam logic [N_OUT*N_IN*16-1:0] W_TRUNC = {
        16'h0200, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0200, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [N_OUT*N_IN*16-1:0] W_WRAP = {
        16'h0400, 16'h0000, 16'h0000, 16'h0000,
        16'h0400, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000};

    initial begin
        s_delta_tdata  = 16'h0000;
        s_delta_tvalid = 1'b0;
        s_w_tdata      = 16'h0000;
        s_w_tvalid     = 1'b0;
        rst_n          = 1'b1;
        #2;

        // Pin the model with hand-computed values
        set_job({16'h0400, 16'h0800, 16'hFC00}, W_BASIC);
        check("model_basic_e0", 32'(model_e(0)), 32'h0400);
        check("model_basic_e1", 32'(model_e(1)), 32'h0800);
        check("model_basic_e2", 32'(model_e(2)), 32'hFC00);
        check("model_basic_e3", 32'(model_e(3)), 32'hFE00);
        set_job({16'h0001, 16'hFFFF, 16'h0000}, W_TRUNC);
        check("model_trunc_pos", 32'(model_e(0)), 32'h0000);
        check("model_trunc_neg", 32'(model_e(1)), 32'hFFFF);
        set_job({16'h7FFF, 16'h7FFF, 16'h0000}, W_WRAP);
        check("model_wrap_e0", 32'(model_e(0)), 32'hFFFE);

        do_reset("reset");

        // Basic job, then the same job under random gaps and backpressure
        set_job({16'h0400, 16'h0800, 16'hFC00}, W_BASIC);
        run_job(1'b0);
        check("busy_low_after_basic", 32'(busy), 32'd0);
        bp_mode = 1'b1;
        run_job(1'b1);
        run_job(1'b1);
        bp_mode = 1'b0;

        set_job({16'h0001, 16'hFFFF, 16'h0000}, W_TRUNC);
        run_job(1'b0);
        set_job({16'h7FFF, 16'h7FFF, 16'h0000}, W_WRAP);
        run_job(1'b0);

        // Abort after the 5th weight beat, then a clean basic job
        set_job({16'h0400, 16'h0800, 16'hFC00}, W_BASIC);
        send(1'b0, job_d[0], 1'b0);
        for (int j = 0; j < N_IN; j++) send(1'b1, job_w[j], 1'b0);
        send(1'b0, job_d[1], 1'b0);
        send(1'b1, job_w[N_IN], 1'b0);
        do_reset("midjob_reset");
        run_job(1'b0);

        // Back-to-back jobs with different deltas
        set_job({16'h0C00, 16'hF800, 16'h0400}, W_BASIC);
        run_job(1'b0);
        set_job({16'h0400, 16'h0800, 16'hFC00}, W_BASIC);
        run_job(1'b0);

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_bp_engine.md
# matrix_bp_engine

Backward-pass engine for the ANN datapath. The forward matrix array computes z[i] = Σj w[i][j]·x[j]. This block computes the transposed product e[j] = Σi w[i][j]·δ[i], so output-layer errors can be propagated back to the previous layer. It uses the same Q6.10 fixed-point format and the same product slicing as the forward PE. Error and weight streams arrive over AXI-Stream-style handshakes (typically from DMA), and the error vector for the previous layer is streamed out.

## Interface
- N_IN, default 4: length of the output error vector e, equal to the forward-pass input width; 1..256.
- N_OUT, default 3: length of the input error vector δ, equal to the forward-pass output width; 1..256.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_delta_tdata  in  16  δ[i], signed Q6.10.
- s_delta_tvalid  in  1  δ beat valid.
- s_delta_tready  out  1  δ beat accepted when high with tvalid.
- s_w_tdata  in  16  w[i][j], signed Q6.10; row-major order, j fastest.
- s_w_tvalid  in  1  weight beat valid.
- s_w_tready  out  1  weight beat accepted.
- m_e_tdata  out  16  e[j], signed Q6.10.
- m_e_tvalid  out  1  result beat valid.
- m_e_tready  in  1  downstream ready.
- m_e_tlast  out  1  high on the e[N_IN-1] beat.
- busy  out  1  high from the first δ handshake of a job until the final e handshake.

## Operation
- Job sequence: for each i = 0..N_OUT-1, one δ[i] beat followed by N_IN weight beats w[i][0..N_IN-1]. After the last row, N_IN result beats are sent.
- Registers:
  - acc[0..N_IN-1]: 16-bit accumulators.
  - d_reg: latched δ.
  - Counters: row i, column j, output index k, each $clog2-sized (minimum 1 bit).
- Arithmetic: 32-bit signed product d_reg·w. The increment is product bits [25:10], which is an arithmetic shift right by 10 (rounds toward −∞). The 16-bit add wraps modulo 2^16, with no saturation.
- States:
  - S_IDLE: clears all acc, i, j and k. Moves to S_DELTA unconditionally on the next cycle.
  - S_DELTA: s_delta_tready=1. On handshake, latch d_reg, set busy, and move to S_WEIGHT.
  - S_WEIGHT: s_w_tready=1. On handshake, acc[j] += (d_reg·w)[25:10] and j++.
    - When j==N_IN-1: set j=0.
    - If i==N_OUT-1, move to S_OUT; otherwise i++ and move to S_DELTA.
  - S_OUT: m_e_tvalid=1, m_e_tdata=acc[k], m_e_tlast=(k==N_IN-1).
    - On handshake, k++.
    - On the handshake with tlast, clear busy and move to S_IDLE.
- Ready/valid outputs are decoded from state only. They never depend combinationally on the opposite-side valid or ready.
- Beats presented on a stream whose tready is low are not consumed. Example: weights offered during S_DELTA wait.
- While m_e_tready=0 in S_OUT, m_e_tdata and m_e_tlast hold stable.

## Timing
- Reset (rst_n low, asynchronous):
  - State is S_IDLE.
  - All acc, d_reg and counters are 0.
  - Outputs: s_delta_tready=0, s_w_tready=0, m_e_tvalid=0, m_e_tdata=0, m_e_tlast=0, busy=0.
- First cycle after rst_n rises: S_IDLE. Second cycle: s_delta_tready=1.
- Throughput is one beat per cycle on whichever stream is active.
  - With no stalls, the input phase takes N_OUT·(1+N_IN) cycles.
  - The first result is valid the cycle after the final weight handshake.
  - The output phase takes N_IN cycles, followed by 1 S_IDLE cycle.
- The final weight's accumulation completes on the same edge that enters S_OUT, so acc[0] is already updated when first presented. This also holds for N_IN=1.
- Reset mid-job aborts immediately. Partial accumulations are discarded, and the next job starts from cleared state.
- Back-to-back jobs have a fixed one-cycle S_IDLE gap between the final e handshake and s_delta_tready=1.

## Test plan
- Basic (N_IN=4, N_OUT=3):
  - Stimulus: δ = 0x0400, 0x0800, 0xFC00. W rows = [0x0400,0,0,0], [0,0x0400,0,0], [0,0,0x0400,0x0200].
  - Required: e = 0x0400, 0x0800, 0xFC00, 0xFE00, with tlast only on the 4th beat and busy low afterwards.
- Backpressure:
  - Stimulus: repeat the basic test with random s_delta_tvalid/s_w_tvalid gaps and m_e_tready toggling 0/1.
  - Required: identical results in order, and m_e_tdata stable whenever tvalid=1 and tready=0.
- Truncation:
  - Stimulus: δ=0x0001, w=0x0200.
  - Required: contribution 0x0000.
  - Stimulus: δ=0xFFFF, w=0x0200.
  - Required: contribution 0xFFFF (floor of −0.5 LSB).
- Wrap:
  - Stimulus: N_OUT=2, both δ=0x7FFF, w[i][0]=0x0400.
  - Required: e[0]=0xFFFE.
- Reset mid-job:
  - Stimulus: drop rst_n after the 5th weight beat.
  - Required: all outputs at reset values in the same cycle. A following basic job yields exactly the basic-test results.
- Back-to-back:
  - Stimulus: two jobs with different δ.
  - Required: second job has no carry-over from the first, and s_delta_tready rises exactly 2 cycles after the first job's tlast handshake.
